// File: rtl/reset_requester.sv
// reset_requester: merges watchdog, debounced button and software triggers into a fixed-width req pulse
module reset_requester #(
  parameter int WDT_CYCLES      = 1000000,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REQ_CYCLES      = 16,
  parameter int HOLDOFF_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  input  logic       button_n,
  input  logic       sw_req,
  input  logic       cause_ack,
  output logic       req,
  output logic [1:0] cause,
  output logic       cause_valid
);
  localparam int WW = $clog2(WDT_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int FM = REQ_CYCLES > HOLDOFF_CYCLES ? REQ_CYCLES : HOLDOFF_CYCLES;
  localparam int FW = FM > 1 ? $clog2(FM) : 1;
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;
  state_t        state;
  logic [1:0]    sync;
  logic          s, d, d_prev, db_end, press, wdt_end, timeout, trig;
  logic [DW-1:0] db_cnt;
  logic [WW-1:0] wdt_cnt;
  logic [FW-1:0] cnt;
  logic [1:0]    src;
  always_comb begin
    s       = sync[1];
    db_end  = db_cnt == DW'(DEBOUNCE_CYCLES - 1);
    press   = d_prev & ~d;
    wdt_end = wdt_cnt == WW'(WDT_CYCLES - 1);
    timeout = wdt_end & wdt_enable & ~wdt_kick;
    trig    = (state == IDLE) & (timeout | press | sw_req);
    src     = timeout ? 2'd1 : press ? 2'd2 : 2'd3;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b11;
      d       <= 1'b1;
      d_prev  <= 1'b1;
      db_cnt  <= '0;
      wdt_cnt <= '0;
    end else begin
      sync    <= {sync[0], button_n};
      d_prev  <= d;
      d       <= (s != d && db_end) ? s : d;
      db_cnt  <= (s == d || db_end) ? '0 : db_cnt + 1'b1;
      wdt_cnt <= (!wdt_enable || wdt_kick || state != IDLE) ? '0 : wdt_end ? wdt_cnt : wdt_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      req         <= 1'b0;
      cause       <= 2'd0;
      cause_valid <= 1'b0;
    end else begin
      cause_valid <= trig | (cause_valid & ~cause_ack);
      cause       <= trig ? src : cause;
      case (state)
        IDLE: if (trig) begin
          state <= ASSERT;
          req   <= 1'b1;
          cnt   <= '0;
        end
        ASSERT: if (cnt == FW'(REQ_CYCLES - 1)) begin
          state <= HOLDOFF;
          req   <= 1'b0;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        HOLDOFF: if (cnt == FW'(HOLDOFF_CYCLES - 1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_requester.sv
// tb_reset_requester: directed self-checking bench for reset_requester
module tb_reset_requester;
  localparam int W = 20, D = 4, R = 3, H = 5;
  logic       clk = 1'b0, reset_n = 1'b0, wdt_enable = 1'b0, wdt_kick = 1'b0;
  logic       button_n = 1'b1, sw_req = 1'b0, cause_ack = 1'b0;
  logic       req, cause_valid;
  logic [1:0] cause;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  reset_requester #(
    .WDT_CYCLES(W), .DEBOUNCE_CYCLES(D), .REQ_CYCLES(R), .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wdt_enable(wdt_enable), .wdt_kick(wdt_kick),
    .button_n(button_n), .sw_req(sw_req), .cause_ack(cause_ack),
    .req(req), .cause(cause), .cause_valid(cause_valid)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input logic [3:0] exp);
    chk(tag, {req, cause, cause_valid}, exp);
  endtask
  task automatic cr(input string tag, input logic e);
    chk(tag, {3'b000, req}, {3'b000, e});
  endtask
  initial begin
    repeat (3) begin
      tick(1);
      st("reset", 4'b0000);
    end
    reset_n = 1'b1;
    repeat (50) begin
      tick(1);
      st("idle", 4'b0000);
    end
    wdt_enable = 1'b1;
    wdt_kick   = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    for (int i = 1; i <= W; i++) begin
      cr("wdt_wait", 1'b0);
      tick(1);
    end
    st("wdt_rise", 4'b1011);
    tick(1);
    cr("wdt_hold1", 1'b1);
    tick(1);
    cr("wdt_hold2", 1'b1);
    wdt_enable = 1'b0;
    tick(1);
    st("wdt_fall", 4'b0011);
    tick(6);
    wdt_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wdt_kick = (i % 19 == 0);
      tick(1);
      cr("kick19", 1'b0);
    end
    wdt_kick = 1'b0;
    repeat (15) begin
      tick(1);
      cr("pre_term", 1'b0);
    end
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    cr("term_kick", 1'b0);
    repeat (W - 1) begin
      tick(1);
      cr("after_term", 1'b0);
    end
    tick(1);
    st("term_timeout", 4'b1011);
    wdt_enable = 1'b0;
    tick(12);
    button_n = 1'b0;
    tick(3);
    button_n = 1'b1;
    repeat (12) begin
      tick(1);
      cr("glitch", 1'b0);
    end
    button_n = 1'b0;
    repeat (6) begin
      tick(1);
      cr("btn_wait", 1'b0);
    end
    tick(1);
    st("btn_rise", 4'b1101);
    tick(1);
    cr("btn_hold1", 1'b1);
    tick(1);
    cr("btn_hold2", 1'b1);
    tick(1);
    st("btn_fall", 4'b0101);
    repeat (90) begin
      tick(1);
      cr("btn_held", 1'b0);
    end
    button_n = 1'b1;
    repeat (12) begin
      tick(1);
      cr("btn_release", 1'b0);
    end
    cause_ack = 1'b1;
    tick(1);
    cause_ack = 1'b0;
    st("ack_btn", 4'b0100);
    button_n = 1'b0;
    repeat (6) begin
      tick(1);
      cr("btn2_wait", 1'b0);
    end
    tick(1);
    st("btn2_rise", 4'b1101);
    tick(3);
    cr("btn2_fall", 1'b0);
    button_n = 1'b1;
    tick(15);
    wdt_enable = 1'b1;
    wdt_kick   = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    tick(W - 1);
    sw_req = 1'b1;
    tick(1);
    sw_req     = 1'b0;
    wdt_enable = 1'b0;
    st("prio", 4'b1011);
    tick(1);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    st("sw_in_assert", 4'b1011);
    tick(1);
    st("prio_fall", 4'b0011);
    tick(1);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    cr("sw_in_holdoff", 1'b0);
    repeat (3) begin
      tick(1);
      cr("holdoff_quiet", 1'b0);
    end
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    st("sw_rise", 4'b1111);
    tick(2);
    cr("sw_hold", 1'b1);
    tick(1);
    st("sw_fall", 4'b0111);
    tick(6);
    cause_ack = 1'b1;
    tick(1);
    cause_ack = 1'b0;
    st("ack_clear", 4'b0110);
    cause_ack = 1'b1;
    sw_req    = 1'b1;
    tick(1);
    cause_ack = 1'b0;
    sw_req    = 1'b0;
    st("ack_vs_trig", 4'b1111);
    tick(10);
    st("cv_kept", 4'b0111);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    cr("mid_first", 1'b1);
    tick(1);
    cr("mid_second", 1'b1);
    #2 reset_n = 1'b0;
    #1 st("async_rst", 4'b0000);
    tick(2);
    st("rst_held", 4'b0000);
    reset_n = 1'b1;
    repeat (12) begin
      tick(1);
      st("post_rst", 4'b0000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
